// File: rtl/hazard_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_seq_if
//   Bundle of the pipeline-side signals seen by the sequential hazard unit.
//   master : pipeline side. It drives the EX/ID register fields, the
//            branch/jump resolution and mem_busy. It receives the controls.
//   slave  : hazard unit. It receives the above and drives hazard_stall,
//            hazard_flush, hazard_mux and hazard_state.
// ---------------------------------------------------------------------------
interface hazard_ctrl_seq_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] ID_EX_rt;
  logic              ID_EX_memread;
  logic [REG_AW-1:0] IF_ID_rs1;
  logic [REG_AW-1:0] IF_ID_rs2;
  logic              IF_ID_use_rs1;
  logic              IF_ID_use_rs2;
  logic              jump_flag;
  logic              correct;
  logic              mem_busy;
  logic              hazard_stall;
  logic              hazard_flush;
  logic              hazard_mux;
  logic [1:0]        hazard_state;

  modport master (
    output ID_EX_rt, ID_EX_memread, IF_ID_rs1, IF_ID_rs2,
           IF_ID_use_rs1, IF_ID_use_rs2, jump_flag, correct, mem_busy,
    input  hazard_stall, hazard_flush, hazard_mux, hazard_state
  );

  modport slave (
    input  ID_EX_rt, ID_EX_memread, IF_ID_rs1, IF_ID_rs2,
           IF_ID_use_rs1, IF_ID_use_rs2, jump_flag, correct, mem_busy,
    output hazard_stall, hazard_flush, hazard_mux, hazard_state
  );
endinterface

// File: rtl/hazard_ctrl_seq.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_seq
//   Sequential hazard unit for the 5-stage RISC-V pipeline. It handles these
//   cases:
//   - Load-use hazards stall for LOAD_LAT cycles.
//   - Branch/jump mispredicts flush for MISS_PENALTY cycles.
//   - A busy data memory freezes the pipeline.
//   Register x0 is never treated as a dependency.
//
// Ports
//   clk, rst : core clock, synchronous active-high reset
//   hz       : hazard_ctrl_seq_if.slave. It carries the EX/ID fields,
//              jump_flag, correct and mem_busy in, and the stall/flush/mux
//              controls plus the debug state out.
//   stall_cnt, flush_cnt, lu_cnt : saturating perf counters. They exist
//              only when HAZARD_PERF_CNT_EN is defined.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
// ---------------------------------------------------------------------------
module hazard_ctrl_seq #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int MISS_PENALTY = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_ctrl_seq_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   lu_cnt
`endif
);

  localparam int MAX_LAT = (LOAD_LAT > MISS_PENALTY) ? LOAD_LAT : MISS_PENALTY;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] MISS_INIT = CW'(MISS_PENALTY - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MISS_FLUSH = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            lu;
  logic            stall, flush, mux;

  assign lu = hz.ID_EX_memread && (hz.ID_EX_rt != REG_AW'(0)) &&
              ((hz.IF_ID_use_rs1 && (hz.ID_EX_rt == hz.IF_ID_rs1)) ||
               (hz.IF_ID_use_rs2 && (hz.ID_EX_rt == hz.IF_ID_rs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    stall      = 1'b0;
    flush      = 1'b0;
    mux        = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!rst) begin
      unique case (state_reg)
        IDLE: begin
          if (hz.mem_busy) begin
            stall      = 1'b1;
            state_next = MEM_WAIT;
          end else if (!hz.correct) begin
            flush = 1'b1;
            mux   = 1'b1;
            if (MISS_PENALTY > 1) begin
              state_next = MISS_FLUSH;
              cnt_next   = MISS_INIT;
            end
          end else if (lu) begin
            // Load-use wins over a concurrent jump. The jump is still
            // sitting in ID after the stall and gets handled then.
            stall = 1'b1;
            flush = 1'b1;
            mux   = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = LOAD_STALL;
              cnt_next   = LOAD_INIT;
            end
          end else if (hz.jump_flag) begin
            flush = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (hz.mem_busy) begin
            stall = 1'b1;
          end else if (!hz.correct) begin
            // A mispredict abandons the remaining stall cycles.
            flush = 1'b1;
            mux   = 1'b1;
            if (MISS_PENALTY > 1) begin
              state_next = MISS_FLUSH;
              cnt_next   = MISS_INIT;
            end else begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          end else begin
            stall    = 1'b1;
            flush    = 1'b1;
            mux      = 1'b1;
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) state_next = IDLE;
          end
        end
        MISS_FLUSH: begin
          if (hz.mem_busy) begin
            stall = 1'b1;
          end else begin
            flush    = 1'b1;
            mux      = 1'b1;
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) state_next = IDLE;
          end
        end
        MEM_WAIT: begin
          stall = 1'b1;
          if (!hz.mem_busy) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign hz.hazard_stall = stall;
  assign hz.hazard_flush = flush;
  assign hz.hazard_mux   = mux;
  assign hz.hazard_state = rst ? 2'd0 : state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic lu_take;

  // Counts the moment the IDLE priority chain selects the load-use branch.
  assign lu_take = !rst && (state_reg == IDLE) && !hz.mem_busy && hz.correct && lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      if (stall && !(&stall_cnt))          stall_cnt <= stall_cnt + 1'b1;
      if (flush && !stall && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (lu_take && !(&lu_cnt))           lu_cnt    <= lu_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_seq
//   Directed bench for hazard_ctrl_seq. It drives two instances from the same
//   stimulus:
//     dut_a : LOAD_LAT=1, MISS_PENALTY=1
//     dut_b : LOAD_LAT=3, MISS_PENALTY=2
//   Each step compares {stall,flush,mux,state} of both against hand-computed
//   values.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rt, rs1, rs2;
  logic       memread, u1, u2, jump, correct, busy;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_seq_if #(.REG_AW(5)) ifa ();
  hazard_ctrl_seq_if #(.REG_AW(5)) ifb ();

  assign ifa.ID_EX_rt      = rt;
  assign ifa.ID_EX_memread = memread;
  assign ifa.IF_ID_rs1     = rs1;
  assign ifa.IF_ID_rs2     = rs2;
  assign ifa.IF_ID_use_rs1 = u1;
  assign ifa.IF_ID_use_rs2 = u2;
  assign ifa.jump_flag     = jump;
  assign ifa.correct       = correct;
  assign ifa.mem_busy      = busy;

  assign ifb.ID_EX_rt      = rt;
  assign ifb.ID_EX_memread = memread;
  assign ifb.IF_ID_rs1     = rs1;
  assign ifb.IF_ID_rs2     = rs2;
  assign ifb.IF_ID_use_rs1 = u1;
  assign ifb.IF_ID_use_rs2 = u2;
  assign ifb.jump_flag     = jump;
  assign ifb.correct       = correct;
  assign ifb.mem_busy      = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sa, fa, la, sb, fb, lb;
`endif

  hazard_ctrl_seq #(.REG_AW(5), .LOAD_LAT(1), .MISS_PENALTY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hz(ifa)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sa), .flush_cnt(fa), .lu_cnt(la)
`endif
  );

  hazard_ctrl_seq #(.REG_AW(5), .LOAD_LAT(3), .MISS_PENALTY(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .hz(ifb)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sb), .flush_cnt(fb), .lu_cnt(lb)
`endif
  );

  task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected values are {stall,flush,mux,state[1:0]}.
  task automatic step(input string tag, input logic [4:0] ea, input logic [4:0] eb);
    logic [4:0] oa, ob;
    #1;
    oa = {ifa.hazard_stall, ifa.hazard_flush, ifa.hazard_mux, ifa.hazard_state};
    ob = {ifb.hazard_stall, ifb.hazard_flush, ifb.hazard_mux, ifb.hazard_state};
    $display("[%0t] %s a=%b b=%b", $time, tag, oa, ob);
    cmp({tag, "/a"}, oa, ea);
    cmp({tag, "/b"}, ob, eb);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rt = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    memread = 1'b0; u1 = 1'b0; u2 = 1'b0;
    jump = 1'b0; correct = 1'b1; busy = 1'b0;
  endtask

  task automatic lu_in();
    idle_in();
    memread = 1'b1; rt = 5'd5; rs1 = 5'd5; u1 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset is forced, even with a load-use and a mispredict present.
    rst = 1'b1;
    lu_in(); correct = 1'b0;
    step("rst_forced0", 5'b000_00, 5'b000_00);
    step("rst_forced1", 5'b000_00, 5'b000_00);
    rst = 1'b0; idle_in();
    step("after_rst", 5'b000_00, 5'b000_00);

    // Load-use: A stalls one cycle, B stalls three cycles (state 0->1->1->0).
    lu_in();
    step("lu_c0", 5'b111_00, 5'b111_00);
    idle_in();
    step("lu_c1", 5'b000_00, 5'b111_01);
    step("lu_c2", 5'b000_00, 5'b111_01);
    step("lu_c3", 5'b000_00, 5'b000_00);

    // x0 is excluded, and unused rs2 is ignored.
    do_reset();
    memread = 1'b1; rt = 5'd0; rs1 = 5'd0; u1 = 1'b1;
    step("x0_load", 5'b000_00, 5'b000_00);
    idle_in(); memread = 1'b1; rt = 5'd7; rs2 = 5'd7; rs1 = 5'd3; u1 = 1'b1;
    step("rs2_unused", 5'b000_00, 5'b000_00);
    u2 = 1'b1;
    step("rs2_used", 5'b111_00, 5'b111_00);

    // Mispredict: B flushes two cycles and ignores a load-use in the 2nd cycle.
    do_reset();
    correct = 1'b0;
    step("miss_c0", 5'b011_00, 5'b011_00);
    lu_in();
    step("miss_c1_lu", 5'b111_00, 5'b011_10);
    idle_in();
    step("miss_c2", 5'b000_00, 5'b000_00);

    // A mispredict in the 2nd stall cycle of B aborts LOAD_STALL.
    do_reset();
    lu_in();
    step("abort_c0", 5'b111_00, 5'b111_00);
    idle_in(); correct = 1'b0;
    step("abort_c1", 5'b011_00, 5'b011_01);
    correct = 1'b1;
    step("abort_c2", 5'b000_00, 5'b011_10);
    step("abort_c3", 5'b000_00, 5'b000_00);

    // A load-use together with a jump: the load pattern comes first.
    do_reset();
    lu_in(); jump = 1'b1;
    step("lu_jump_c0", 5'b111_00, 5'b111_00);
    idle_in(); jump = 1'b1;
    step("lu_jump_c1", 5'b010_00, 5'b111_01);
    step("lu_jump_c2", 5'b010_00, 5'b111_01);
    step("lu_jump_c3", 5'b010_00, 5'b010_00);
    idle_in();
    step("lu_jump_c4", 5'b000_00, 5'b000_00);

    // mem_busy for 4 cycles: it freezes B mid MISS_FLUSH and puts A in MEM_WAIT.
    do_reset();
    correct = 1'b0;
    step("busy_c0", 5'b011_00, 5'b011_00);
    correct = 1'b1; busy = 1'b1;
    step("busy_c1", 5'b100_00, 5'b100_10);
    step("busy_c2", 5'b100_11, 5'b100_10);
    step("busy_c3", 5'b100_11, 5'b100_10);
    step("busy_c4", 5'b100_11, 5'b100_10);
    busy = 1'b0;
    step("busy_c5", 5'b100_11, 5'b011_10);
    step("busy_c6", 5'b000_00, 5'b000_00);

    // Reset asserted in the middle of a LOAD_STALL.
    do_reset();
    lu_in();
    step("rstmid_c0", 5'b111_00, 5'b111_00);
    idle_in();
    step("rstmid_c1", 5'b000_00, 5'b111_01);
    rst = 1'b1;
    step("rstmid_rst", 5'b000_00, 5'b000_00);
    rst = 1'b0;
    step("rstmid_after", 5'b000_00, 5'b000_00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_seq.md
Name: hazard_ctrl_seq

Overview:
- Parametrised, sequential successor to the pipeline hazard unit in the 5-stage RISC-V core.
- Drives stall, flush and bubble-mux controls for the IF/ID/EX stages.
- Handles load-use hazards with a configurable load latency and branch/jump mispredicts with a configurable multi-cycle flush penalty.
- Freezes the whole pipeline while data memory is busy and excludes x0 from dependency checks.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, stall cycles per load-use hazard (>=1).
- MISS_PENALTY, 1, flush cycles per mispredict (>=1).
- CNT_W, 16, width of optional perf counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset. Synchronous, active-high.
- ID_EX_rt  in  REG_AW  destination register of the instruction in EX.
- ID_EX_memread  in  1  instruction in EX is a load.
- IF_ID_rs1  in  REG_AW  source 1 of the instruction in ID.
- IF_ID_rs2  in  REG_AW  source 2 of the instruction in ID.
- IF_ID_use_rs1  in  1  ID instruction reads rs1.
- IF_ID_use_rs2  in  1  ID instruction reads rs2 (0 for jalr, I-type, jal).
- jump_flag  in  1  jal/jalr resolved in ID.
- correct  in  1  branch prediction correct (0 = mispredict).
- mem_busy  in  1  D-memory/cache not ready.
- hazard_stall  out  1  hold PC and IF/ID.
- hazard_flush  out  1  flush IF/ID.
- hazard_mux  out  1  insert bubble into ID/EX.
- hazard_state  out  2  FSM state (debug).

Behaviour:
- Load-use detect (comb), lu =
  - ID_EX_memread && ID_EX_rt!=0 && ((IF_ID_use_rs1 && ID_EX_rt==IF_ID_rs1) || (IF_ID_use_rs2 && ID_EX_rt==IF_ID_rs2)).
- FSM states: IDLE=0, LOAD_STALL=1, MISS_FLUSH=2, MEM_WAIT=3. Down-counter cnt has width clog2(max(LOAD_LAT, MISS_PENALTY))+1.
- Reset: while rst=1, state=IDLE, cnt=0, and all outputs 0 (forced, regardless of inputs).
- Outputs are combinational from state and inputs, giving 0-cycle response in IDLE.
- IDLE priority:
  - mem_busy: freeze, stall=1/flush=0/mux=0, next=MEM_WAIT.
  - else correct==0: stall=0/flush=1/mux=1. If MISS_PENALTY>1, next=MISS_FLUSH with cnt=MISS_PENALTY-1.
  - else lu: stall=1/flush=1/mux=1. If LOAD_LAT>1, next=LOAD_STALL with cnt=LOAD_LAT-1.
  - else jump_flag: stall=0/flush=1/mux=0.
  - else all 0.
- LOAD_STALL:
  - Outputs stall=1/flush=1/mux=1; cnt decrements each cycle.
  - Returns to IDLE in the cycle cnt==1 (outputs still asserted that cycle).
  - correct==0 aborts: outputs become the mispredict pattern and next=MISS_FLUSH with cnt=MISS_PENALTY-1, or IDLE if MISS_PENALTY==1.
- MISS_FLUSH:
  - Outputs stall=0/flush=1/mux=1; cnt decrements each cycle.
  - Exits to IDLE when cnt==1.
  - lu, jump_flag and correct are ignored.
- MEM_WAIT:
  - Outputs stall=1/flush=0/mux=0; cnt is held.
  - When mem_busy falls, next=IDLE and the inputs are re-evaluated in that following cycle.
- mem_busy in LOAD_STALL or MISS_FLUSH: outputs are the freeze pattern and cnt is held. The state is preserved; MEM_WAIT is entered only from IDLE.
- Simultaneous lu and jump_flag in IDLE: lu wins. The jump is re-evaluated after the stall.
- Reset mid-LOAD_STALL or mid-MISS_FLUSH: next cycle is IDLE with cnt=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[CNT_W], flush_cnt[CNT_W] and lu_cnt[CNT_W].
  - stall_cnt increments each cycle hazard_stall=1.
  - flush_cnt increments each cycle hazard_flush=1 && hazard_stall=0.
  - lu_cnt increments on each IDLE->load-use entry.
  - All counters saturate at all-ones and clear on rst.
- When undefined, these ports and registers are absent and the rest of the behaviour is identical.

Test Plan:
- LOAD_LAT=1: ID_EX_memread=1, ID_EX_rt=5, IF_ID_rs1=5, use_rs1=1 -> stall/flush/mux=1 for exactly 1 cycle, then 0.
- LOAD_LAT=3, same hazard -> 1/1/1 for 3 cycles, hazard_state 0->1->1->0.
- ID_EX_rt=0 with rs1=0 load, or rt=rs2 with use_rs2=0 -> outputs stay 0.
- MISS_PENALTY=2: correct=0 for 1 cycle -> flush=1/mux=1/stall=0 for 2 cycles. A load-use during the 2nd cycle is ignored.
- correct=0 in the 2nd cycle of a LOAD_LAT=3 stall -> mispredict pattern immediately, then LOAD_STALL abandoned; jump_flag with lu in IDLE -> load pattern first.
- mem_busy=1 for 4 cycles mid-MISS_FLUSH -> stall=1/flush=0 for 4 cycles, remaining flush cycles resume after. Assert rst mid-LOAD_STALL -> outputs 0 and state 0 next cycle.
